vc_dest_arbiter: RTL and testbench

Arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transaction layer. Each cycle it pops at most one word from a VC head and forwards it, one cycle later, to the destination FIFO selected by a routing bit in the word. It respects the destination almost-full (pause) flags and applies VC0 priority with a bounded-starvation rule for VC1. It runs only while the transaction state machine reports ACTIVE.

---
 rtl/trans_pkg.sv | 19 +
 rtl/vc_dest_arbiter.sv | 107 ++++++++++
 tb/tb_vc_dest_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/trans_pkg.sv
// Shared transaction-layer constants: VC indices, destination encoding and
// the grant type used by the VC-to-destination arbiter.
package trans_pkg;

   localparam int DEFAULT_DATA_WIDTH = 6;

   localparam int VC0 = 0;
   localparam int VC1 = 1;

   localparam logic D0 = 1'b0;
   localparam logic D1 = 1'b1;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_VC0  = 2'd1,
      GRANT_VC1  = 2'd2
   } grant_e;

endpackage

// File: rtl/vc_dest_arbiter.sv
// Pops one word per cycle from VC0/VC1 (VC0 priority, bounded VC1 starvation)
// and forwards it one cycle later to the destination FIFO chosen by DEST_BIT.
module vc_dest_arbiter
   import trans_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEST_BIT   = 4,
   parameter int VC0_BURST  = 3,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]  d0_count,
   output logic [CNT_WIDTH-1:0]  d1_count
);

   localparam int BURST_W = (VC0_BURST < 1) ? 1 : $clog2(VC0_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(VC0_BURST);

   logic [BURST_W-1:0]    r_burst_cnt;
   logic                  r_d0_push;
   logic                  r_d1_push;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic [CNT_WIDTH-1:0]  r_d0_count;
   logic [CNT_WIDTH-1:0]  r_d1_count;

   logic [1:0]            w_elig;
   grant_e                w_grant;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_sel_dest;

   // Pause flag is looked up per head, so a blocked VC0 never stalls VC1.
   always_comb begin
      w_elig     = '0;
      w_grant    = GRANT_NONE;
      w_sel_data = vc0_data;
      w_sel_dest = D0;
      if (reset && enable) begin
         w_elig[VC0] = ~vc0_empty &
                       ~((vc0_data[DEST_BIT] == D1) ? d1_almost_full : d0_almost_full);
         w_elig[VC1] = ~vc1_empty &
                       ~((vc1_data[DEST_BIT] == D1) ? d1_almost_full : d0_almost_full);
      end
      if (w_elig[VC0] && w_elig[VC1]) begin
         w_grant = (r_burst_cnt == BURST_MAX) ? GRANT_VC1 : GRANT_VC0;
      end else if (w_elig[VC0]) begin
         w_grant = GRANT_VC0;
      end else if (w_elig[VC1]) begin
         w_grant = GRANT_VC1;
      end
      if (w_grant == GRANT_VC1) begin
         w_sel_data = vc1_data;
      end
      w_sel_dest = w_sel_data[DEST_BIT];
   end

   assign vc0_pop = (w_grant == GRANT_VC0);
   assign vc1_pop = (w_grant == GRANT_VC1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_burst_cnt <= '0;
         r_d0_push   <= 1'b0;
         r_d1_push   <= 1'b0;
         r_data_out  <= '0;
         r_d0_count  <= '0;
         r_d1_count  <= '0;
      end else begin
         r_d0_push <= (w_grant != GRANT_NONE) && (w_sel_dest == D0);
         r_d1_push <= (w_grant != GRANT_NONE) && (w_sel_dest == D1);
         if (w_grant != GRANT_NONE) begin
            r_data_out <= w_sel_data;
         end
         if (r_d0_push) begin
            r_d0_count <= r_d0_count + CNT_WIDTH'(1);
         end
         if (r_d1_push) begin
            r_d1_count <= r_d1_count + CNT_WIDTH'(1);
         end
         // Burst count only tracks VC0 wins while VC1 is actually waiting.
         if (!w_elig[VC1] || (w_grant == GRANT_VC1)) begin
            r_burst_cnt <= '0;
         end else if ((w_grant == GRANT_VC0) && (r_burst_cnt != BURST_MAX)) begin
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
         end
      end
   end

   assign d0_push  = r_d0_push;
   assign d1_push  = r_d1_push;
   assign data_out = r_data_out;
   assign d0_count = r_d0_count;
   assign d1_count = r_d1_count;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: reset, routing, starvation bound,
// pause/bypass, disable mid-stream and counter wrap.
module tb_vc_dest_arbiter;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       vc0_empty;
   logic       vc1_empty;
   logic [5:0] vc0_data;
   logic [5:0] vc1_data;
   logic       d0_almost_full;
   logic       d1_almost_full;
   logic       vc0_pop;
   logic       vc1_pop;
   logic       d0_push;
   logic       d1_push;
   logic [5:0] data_out;
   logic [7:0] d0_count;
   logic [7:0] d1_count;

   int vectors;
   int miscompares;

   vc_dest_arbiter #(
      .DATA_WIDTH(6),
      .DEST_BIT  (4),
      .VC0_BURST (3),
      .CNT_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .vc0_empty     (vc0_empty),
      .vc1_empty     (vc1_empty),
      .vc0_data      (vc0_data),
      .vc1_data      (vc1_data),
      .d0_almost_full(d0_almost_full),
      .d1_almost_full(d1_almost_full),
      .vc0_pop       (vc0_pop),
      .vc1_pop       (vc1_pop),
      .d0_push       (d0_push),
      .d1_push       (d1_push),
      .data_out      (data_out),
      .d0_count      (d0_count),
      .d1_count      (d1_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic e0, input logic [5:0] v0,
                        input logic e1, input logic [5:0] v1,
                        input logic af0, input logic af1);
      enable         = en;
      vc0_empty      = e0;
      vc0_data       = v0;
      vc1_empty      = e1;
      vc1_data       = v1;
      d0_almost_full = af0;
      d1_almost_full = af1;
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // Reset held with non-empty FIFOs and enable high
      reset = 1'b0;
      drive(1'b1, 1'b0, 6'h05, 1'b0, 6'h01, 1'b0, 1'b0);
      step();
      step();
      chk("rst_vc0_pop", vc0_pop, 0);
      chk("rst_vc1_pop", vc1_pop, 0);
      chk("rst_d0_push", d0_push, 0);
      chk("rst_d1_push", d1_push, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_d0_count", d0_count, 0);
      chk("rst_d1_count", d1_count, 0);

      // Routing: VC0 holds 05 then 15, VC1 empty
      reset = 1'b1;
      drive(1'b1, 1'b0, 6'h05, 1'b1, 6'h01, 1'b0, 1'b0);
      chk("rt_pop0_a", vc0_pop, 1);
      chk("rt_pop1_a", vc1_pop, 0);
      chk("rt_d0_push_a", d0_push, 0);
      step();
      drive(1'b1, 1'b0, 6'h15, 1'b1, 6'h01, 1'b0, 1'b0);
      chk("rt_pop0_b", vc0_pop, 1);
      chk("rt_d0_push_b", d0_push, 1);
      chk("rt_d1_push_b", d1_push, 0);
      chk("rt_data_b", data_out, 6'h05);
      step();
      drive(1'b1, 1'b1, 6'h15, 1'b1, 6'h01, 1'b0, 1'b0);
      chk("rt_pop0_c", vc0_pop, 0);
      chk("rt_d0_push_c", d0_push, 0);
      chk("rt_d1_push_c", d1_push, 1);
      chk("rt_data_c", data_out, 6'h15);
      chk("rt_d0_count_c", d0_count, 1);
      step();
      chk("rt_d1_push_d", d1_push, 0);
      chk("rt_data_hold", data_out, 6'h15);
      chk("rt_d0_count_d", d0_count, 1);
      chk("rt_d1_count_d", d1_count, 1);

      // Starvation bound: both toward D0, expect VC0,VC0,VC0,VC1 repeating
      drive(1'b1, 1'b0, 6'h05, 1'b0, 6'h0A, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("sv_vc0_pop", vc0_pop, ((i % 4) != 3) ? 1 : 0);
         chk("sv_vc1_pop", vc1_pop, ((i % 4) == 3) ? 1 : 0);
         if (i > 0) begin
            chk("sv_d0_push", d0_push, 1);
            chk("sv_data", data_out, (((i - 1) % 4) == 3) ? 6'h0A : 6'h05);
         end
         step();
      end

      // Pause and bypass: VC0 head to paused D1, VC1 head to D0
      drive(1'b1, 1'b0, 6'h15, 1'b0, 6'h0A, 1'b0, 1'b1);
      chk("pb_d0_push_s8", d0_push, 1);
      chk("pb_data_s8", data_out, 6'h0A);
      chk("pb_d0_count_s8", d0_count, 8);
      chk("pb_vc0_pop_s8", vc0_pop, 0);
      chk("pb_vc1_pop_s8", vc1_pop, 1);
      step();
      drive(1'b1, 1'b0, 6'h15, 1'b1, 6'h0A, 1'b0, 1'b1);
      chk("pb_vc0_held", vc0_pop, 0);
      chk("pb_vc1_pop_s9", vc1_pop, 0);
      chk("pb_d0_push_s9", d0_push, 1);
      step();
      drive(1'b1, 1'b0, 6'h15, 1'b1, 6'h0A, 1'b0, 1'b0);
      chk("pb_vc0_resume", vc0_pop, 1);
      chk("pb_d0_push_s10", d0_push, 0);
      chk("pb_d1_push_s10", d1_push, 0);
      chk("pb_d0_count_s10", d0_count, 10);
      step();
      chk("pb_d1_push_s11", d1_push, 1);
      chk("pb_data_s11", data_out, 6'h15);

      // Disable mid-stream: grant in S11, enable drops in S12
      drive(1'b1, 1'b0, 6'h05, 1'b1, 6'h0A, 1'b0, 1'b0);
      chk("ds_vc0_pop", vc0_pop, 1);
      step();
      drive(1'b0, 1'b0, 6'h05, 1'b0, 6'h0A, 1'b0, 1'b0);
      chk("ds_pop0_off", vc0_pop, 0);
      chk("ds_pop1_off", vc1_pop, 0);
      chk("ds_inflight_push", d0_push, 1);
      chk("ds_inflight_data", data_out, 6'h05);
      chk("ds_d1_count", d1_count, 2);
      step();
      chk("ds_d0_push_idle", d0_push, 0);
      chk("ds_d1_push_idle", d1_push, 0);
      chk("ds_d0_count", d0_count, 11);
      step();
      chk("ds_pop0_idle2", vc0_pop, 0);
      chk("ds_d0_push_idle2", d0_push, 0);

      // Both destinations paused: no pops
      drive(1'b1, 1'b0, 6'h05, 1'b0, 6'h15, 1'b1, 1'b1);
      chk("af_both_pop0", vc0_pop, 0);
      chk("af_both_pop1", vc1_pop, 0);
      step();

      // Counter wrap: fresh reset, then 257 words to D0
      reset = 1'b0;
      drive(1'b1, 1'b1, 6'h05, 1'b1, 6'h0A, 1'b0, 1'b0);
      step();
      chk("wr_rst_d0_count", d0_count, 0);
      reset = 1'b1;
      drive(1'b1, 1'b0, 6'h05, 1'b1, 6'h0A, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         step();
      end
      drive(1'b1, 1'b1, 6'h05, 1'b1, 6'h0A, 1'b0, 1'b0);
      step();
      chk("wr_d0_count_256", d0_count, 0);
      drive(1'b1, 1'b0, 6'h05, 1'b1, 6'h0A, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b1, 6'h05, 1'b1, 6'h0A, 1'b0, 1'b0);
      step();
      chk("wr_d0_count_257", d0_count, 1);
      chk("wr_d1_count", d1_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
